// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Register offsets and debouncer state encoding for mmio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [7:0] OFF_LEDS   = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_TCOUNT = 8'h08;
    localparam logic [7:0] OFF_TCMP   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    typedef enum logic [0:0] {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_if
// Description : Processor data-port bus between the core and mmio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_if;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        IoSel;

    modport master (
        output DataAdr, WriteData, MemWrite,
        input  ReadData, IoSel
    );

    modport slave (
        input  DataAdr, WriteData, MemWrite,
        output ReadData, IoSel
    );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchronizer plus whole-vector debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
    import mmio_pkg::*;
#(
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [SW_W-1:0] sw_raw,
    output logic      [SW_W-1:0] sw_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync1_q, sync1_d;
    logic [SW_W-1:0]  sync2_q, sync2_d;
    logic [SW_W-1:0]  prev_q, prev_d;
    logic [SW_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] w_cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            state_q  <= DB_STABLE;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign w_cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        sync1_d  = sw_raw;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        if (sync2_q == stable_q) begin
            cnt_d   = '0;
            state_d = DB_STABLE;
        end else if (sync2_q != prev_q) begin
            // Input still moving: restart the stability window.
            cnt_d   = '0;
            state_d = DB_PENDING;
        end else if (w_cnt_inc == c_last_cnt) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            state_d  = DB_STABLE;
        end else begin
            cnt_d   = w_cnt_inc;
            state_d = DB_PENDING;
        end
    end

    assign sw_stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_ctrl
// Description : I/O window decode, LED register, switch input, interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int          SW_W            = 10,
    parameter int          LED_W           = 10,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mmio_if.slave                 bus,
    input  wire logic [SW_W-1:0]  switches,
    output logic      [LED_W-1:0] leds,
    output logic                  irq
);

    logic [LED_W-1:0] leds_q, leds_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      tcmp_q, tcmp_d;
    logic             flag_q, flag_d;

    logic             w_io_sel;
    logic             w_we;
    logic             w_match;
    logic [7:0]       w_off;
    logic [SW_W-1:0]  w_sw;
    logic [31:0]      w_rdata;

    sw_debounce #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (switches),
        .sw_stable (w_sw)
    );

    assign w_io_sel = (bus.DataAdr[31:8] == IO_BASE[31:8]);
    assign w_off    = bus.DataAdr[7:0] & 8'hFC;
    assign w_we     = bus.MemWrite & w_io_sel;
    assign w_match  = (tcmp_q != 32'd0) && (count_q == tcmp_q);

    always_comb begin
        w_rdata = '0;
        if (w_io_sel) begin
            case (w_off)
                OFF_LEDS:   w_rdata = 32'(leds_q);
                OFF_SW:     w_rdata = 32'(w_sw);
                OFF_TCOUNT: w_rdata = count_q;
                OFF_TCMP:   w_rdata = tcmp_q;
                OFF_STATUS: w_rdata = {31'd0, flag_q};
                default:    w_rdata = '0;
            endcase
        end
    end

    always_comb begin
        leds_d  = leds_q;
        tcmp_d  = tcmp_q;
        flag_d  = flag_q;
        count_d = count_q + 32'd1;
        if (w_match) begin
            count_d = '0;
            flag_d  = 1'b1;
        end
        if (w_we) begin
            case (w_off)
                OFF_LEDS:   leds_d  = bus.WriteData[LED_W-1:0];
                OFF_TCOUNT: count_d = '0;
                OFF_TCMP:   tcmp_d  = bus.WriteData;
                // A match in the same cycle keeps the flag set.
                OFF_STATUS: if (bus.WriteData[0] && !w_match) flag_d = 1'b0;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q  <= '0;
            count_q <= '0;
            tcmp_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            count_q <= count_d;
            tcmp_q  <= tcmp_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.ReadData = w_rdata;
    assign bus.IoSel    = w_io_sel;
    assign leds         = leds_q;
    assign irq          = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_ctrl
// Description : Directed scoreboard bench for mmio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_ctrl;

    localparam logic [31:0] A_LEDS   = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW     = 32'hFFFF_FF04;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_FF08;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_FF0C;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF10;
    localparam logic [31:0] A_UNMAP  = 32'hFFFF_FF14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] switches = '0;
    logic [9:0] leds;
    logic       irq;

    mmio_if bus();

    mmio_ctrl #(
        .SW_W            (10),
        .LED_W           (10),
        .DEBOUNCE_CYCLES (16),
        .IO_BASE         (32'hFFFF_FF00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .switches (switches),
        .leds     (leds),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        observe(obs);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string tag);
        bus.DataAdr  = addr;
        bus.MemWrite = 1'b0;
        expect_val(tag, e);
        #1;
        observe(bus.ReadData);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.DataAdr   = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        bus.WriteData = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;

        // Power-on reset state
        #2;
        chk("por_leds", 32'(leds), 32'd0);
        chk("por_irq", {31'd0, irq}, 32'd0);
        rd(A_TCOUNT, 32'd0, "por_tcount");
        rd(A_TCMP,   32'd0, "por_tcmp");
        rd(A_SW,     32'd0, "por_sw");
        rd(A_STATUS, 32'd0, "por_status");
        @(negedge clk) reset = 1'b0;
        cyc(1);

        // LED register and window decode
        wr(A_LEDS, 32'hFFFF_F3A5);
        chk("leds_write", 32'(leds), 32'h3A5);
        rd(A_LEDS, 32'h3A5, "leds_read");
        chk("iosel_in", {31'd0, bus.IoSel}, 32'd1);
        rd(32'h0000_0040, 32'd0, "rd_outside");
        chk("iosel_out", {31'd0, bus.IoSel}, 32'd0);
        wr(32'h0000_0040, 32'hFFFF_F3A5 ^ 32'h3FF);
        chk("leds_outside_wr", 32'(leds), 32'h3A5);

        // Unmapped offset
        rd(A_UNMAP, 32'd0, "rd_unmapped");
        wr(A_UNMAP, 32'hFFFF_FFFF);
        chk("unmap_leds", 32'(leds), 32'h3A5);
        rd(A_TCMP,   32'd0, "unmap_tcmp");
        rd(A_STATUS, 32'd0, "unmap_status");

        // Debounce latency
        switches = 10'h004;
        cyc(17);
        rd(A_SW, 32'd0, "sw_17_edges");
        cyc(1);
        rd(A_SW, 32'd4, "sw_18_edges");
        switches = 10'h000;
        cyc(20);
        rd(A_SW, 32'd0, "sw_back_to_0");
        // Short glitch must be rejected
        switches = 10'h004;
        cyc(5);
        switches = 10'h000;
        cyc(30);
        rd(A_SW, 32'd0, "sw_glitch");

        // Timer period
        wr(A_TCMP, 32'd9);
        wr(A_TCOUNT, 32'h0);
        chk("tmr_irq_start", {31'd0, irq}, 32'd0);
        cyc(9);
        rd(A_TCOUNT, 32'd9, "tmr_cnt9");
        chk("tmr_irq_pre", {31'd0, irq}, 32'd0);
        cyc(1);
        chk("tmr_irq_rise", {31'd0, irq}, 32'd1);
        rd(A_TCOUNT, 32'd0, "tmr_cnt_wrap");
        cyc(9);
        rd(A_TCOUNT, 32'd9, "tmr_period_9");
        cyc(1);
        rd(A_TCOUNT, 32'd0, "tmr_period_0");
        rd(A_STATUS, 32'd1, "status_set");
        wr(A_STATUS, 32'd1);
        chk("status_clear_irq", {31'd0, irq}, 32'd0);
        rd(A_STATUS, 32'd0, "status_cleared");

        // STATUS clear in the match cycle: set wins
        cyc(8);
        rd(A_TCOUNT, 32'd9, "col1_cnt9");
        wr(A_STATUS, 32'd1);
        chk("col1_irq", {31'd0, irq}, 32'd1);
        rd(A_TCOUNT, 32'd0, "col1_cnt0");

        // TCOUNT write in the match cycle
        wr(A_STATUS, 32'd1);
        chk("col2_irq_clr", {31'd0, irq}, 32'd0);
        cyc(8);
        rd(A_TCOUNT, 32'd9, "col2_cnt9");
        wr(A_TCOUNT, 32'h1234);
        rd(A_TCOUNT, 32'd0, "col2_cnt0");
        chk("col2_irq", {31'd0, irq}, 32'd1);

        // Asynchronous reset mid-count and mid-debounce
        wr(A_TCMP, 32'd5);
        switches = 10'h004;
        cyc(5);
        chk("pre_rst_leds", 32'(leds), 32'h3A5);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(A_TCOUNT, 32'd0, "rst_tcount");
        rd(A_TCMP,   32'd0, "rst_tcmp");
        rd(A_SW,     32'd0, "rst_sw");
        @(negedge clk) reset = 1'b0;
        cyc(2);
        rd(A_TCOUNT, 32'd2, "post_rst_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
